// File: rtl/aes_pkg.sv
// Shared AES round-datapath definitions: reduction polynomial, xtime, column type.
// The column type orders bytes so element 0 is row 0, which sits in bits [31:24].
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef logic [0:3][7:0] column_t;

  // Multiply by x in GF(2^8) reduced by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_pipe_if.sv
// Beat interface of the MixColumns engine.
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// The producer holds valid, data and mode stable until that edge, and ready
// never depends combinationally on valid of the same channel.
interface mix_columns_pipe_if #(
  parameter int NCOL = 4
);
  localparam int W = 32 * NCOL;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         err_inv;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, err_inv
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, err_inv
  );

endinterface

// File: rtl/mix_columns_pipe_comb.sv
// Combines the registered byte products of one column into its MixColumns
// (or, with INV_MIX_EN defined, InvMixColumns) result. Pure XOR network.
module mix_column_comb
  import aes_pkg::*;
(
  output column_t res,
  input  column_t x1,
  input  column_t x2
`ifdef INV_MIX_EN
  ,
  input  column_t x4,
  input  column_t x8,
  input  logic    inv
`endif
);

  for (genvar i = 0; i < 4; i++) begin : g_row
    localparam logic [1:0] I0 = 2'(i);
    localparam logic [1:0] I1 = 2'((i + 1) % 4);
    localparam logic [1:0] I2 = 2'((i + 2) % 4);
    localparam logic [1:0] I3 = 2'((i + 3) % 4);

    logic [7:0] fwd;
    // 2*a0 ^ 3*a1 ^ a2 ^ a3, rotated per row
    assign fwd = x2[I0] ^ x2[I1] ^ x1[I1] ^ x1[I2] ^ x1[I3];

`ifdef INV_MIX_EN
    logic [7:0] rev;
    // 14 = 8^4^2, 11 = 8^2^1, 13 = 8^4^1, 9 = 8^1
    assign rev = (x8[I0] ^ x4[I0] ^ x2[I0])
               ^ (x8[I1] ^ x2[I1] ^ x1[I1])
               ^ (x8[I2] ^ x4[I2] ^ x1[I2])
               ^ (x8[I3] ^ x1[I3]);
    assign res[i] = inv ? rev : fwd;
`else
    assign res[i] = fwd;
`endif
  end

endmodule

// File: rtl/mix_columns_pipe.sv
// Two-stage pipelined AES MixColumns engine, NCOL columns per beat.
// S1 registers per-byte GF(2^8) products, S2 registers the combined result.
// Optional feature macro: INV_MIX_EN adds InvMixColumns selected by in_inv;
// without it in_inv only drives the sticky err_inv flag.
module mix_columns_pipe
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input logic               clk,
  input logic               rst_n,
  mix_columns_pipe_if.slave bus
);

  localparam int W = 32 * NCOL;

  // Whole pipeline moves together; a stalled S2 freezes S1 too, so bubbles
  // are kept rather than collapsed.
  logic en;
  assign en         = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  column_t in_x1 [NCOL];
  column_t in_x2 [NCOL];
  column_t s1_x1 [NCOL];
  column_t s1_x2 [NCOL];
  logic    s1_valid;
`ifdef INV_MIX_EN
  column_t in_x4 [NCOL];
  column_t in_x8 [NCOL];
  column_t s1_x4 [NCOL];
  column_t s1_x8 [NCOL];
  logic    s1_inv;
`endif

  column_t      res [NCOL];
  logic [W-1:0] res_flat;
  logic [W-1:0] out_data_q;
  logic         out_valid_q;

  // Per-byte xtime products of the incoming beat
  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      in_x1[c] = bus.in_data[32*c +: 32];
      for (int b = 0; b < 4; b++) begin
        in_x2[c][b] = xtime(in_x1[c][b]);
`ifdef INV_MIX_EN
        in_x4[c][b] = xtime(in_x2[c][b]);
        in_x8[c][b] = xtime(in_x4[c][b]);
`endif
      end
    end
  end

  // S1: capture products, mode and valid when the pipeline advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        s1_x1[c] <= '0;
        s1_x2[c] <= '0;
`ifdef INV_MIX_EN
        s1_x4[c] <= '0;
        s1_x8[c] <= '0;
`endif
      end
`ifdef INV_MIX_EN
      s1_inv <= 1'b0;
`endif
    end else if (en) begin
      s1_valid <= bus.in_valid;
      for (int c = 0; c < NCOL; c++) begin
        s1_x1[c] <= in_x1[c];
        s1_x2[c] <= in_x2[c];
`ifdef INV_MIX_EN
        s1_x4[c] <= in_x4[c];
        s1_x8[c] <= in_x8[c];
`endif
      end
`ifdef INV_MIX_EN
      s1_inv <= bus.in_inv;
`endif
    end
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    mix_column_comb u_comb (
      .res (res[c]),
      .x1  (s1_x1[c]),
      .x2  (s1_x2[c])
`ifdef INV_MIX_EN
      ,
      .x4  (s1_x4[c]),
      .x8  (s1_x8[c]),
      .inv (s1_inv)
`endif
    );
    assign res_flat[32*c +: 32] = res[c];
  end

  // S2: register the combined columns as the output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid;
      out_data_q  <= res_flat;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef INV_MIX_EN
  assign bus.err_inv = 1'b0;
`else
  logic err_inv_q;

  // Sticky: an inverse request accepted by a forward-only engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_inv_q <= 1'b0;
    end else if (bus.in_valid & en & bus.in_inv) begin
      err_inv_q <= 1'b1;
    end
  end

  assign bus.err_inv = err_inv_q;
`endif

endmodule

// File: doc/mix_columns_pipe.md
# mix_columns_pipe

Pipelined, parametrised AES MixColumns engine built on the GF(2^8) xtime multiplier (×2/×3) of the round datapath. It processes NCOL 32-bit state columns per beat through a fixed two-stage pipeline with valid/ready flow control. Optionally, it also computes InvMixColumns. It sits between ShiftRows and AddRoundKey in the pipelined round, replacing the per-byte combinational multiplier instances.

## Interface
- NCOL, default 4: columns per beat, legal 1..4; data width W = 32*NCOL
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat this cycle
- in_data  in  W  column c occupies [32c+31:32c]; within a column, byte a0 (row 0) is [31:24] and a3 is [7:0]
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_data  out  W  transformed columns, same layout as in_data
- err_inv  out  1  sticky flag: an inverse request arrived in a forward-only build

## Operation
- GF(2^8) uses the polynomial 0x11B: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00). All arithmetic is 8-bit XOR/xtime, with no carries.
- Forward transform, per column: r_i = 2·a_i ^ 3·a_(i+1) ^ a_(i+2) ^ a_(i+3), with indices mod 4.
- Inverse transform: r_i = 14·a_i ^ 11·a_(i+1) ^ 13·a_(i+2) ^ 9·a_(i+3), built from x2/x4/x8 products.
- Stage 1 (S1) registers x1, x2, x4 and x8 of every byte, plus the inv bit and s1_valid. In a forward-only build, x4 and x8 are omitted.
- Stage 2 (S2) registers the XOR combination as out_data, together with out_valid.
- Global advance enable: en = !out_valid | out_ready. Then in_ready = en.
- When en = 1: S1 captures the input (s1_valid <= in_valid), and S2 captures S1 (out_valid <= s1_valid). When en = 0, every register holds its value.
- A bubble in S1 is not collapsed while S2 is stalled.
- All columns in a beat use the same mode.

## Timing
- Reset values: in_ready = 1 (because out_valid = 0), out_valid = 0, out_data = 0, err_inv = 0. All S1 registers are also 0.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+1, i.e. in the cycle following edge N+1. That is two registered stages.
- Throughput: one beat per cycle while out_ready = 1.
- out_data and out_valid stay stable while out_valid & !out_ready.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- in_valid = 0 while in_ready = 1 inserts a bubble, and out_valid later drops for one cycle.
- Asserting rst_n low mid-operation immediately clears both stages. In-flight beats are discarded. No output is produced for them after reset release.
- err_inv sets on the edge where in_valid & in_ready & in_inv occur in a forward-only build. It clears only on reset.

## Configuration
- INV_MIX_EN defined:
  - in_inv selects the inverse transform per beat.
  - err_inv is tied to 0.
- INV_MIX_EN undefined:
  - The inverse datapath and the x4/x8 registers are not built.
  - in_inv is ignored for data, and the forward transform is always applied.
  - err_inv operates as the sticky flag described above.

## Structure
- Shared package aes_pkg holds:
  - constant GF_POLY = 8'h1B;
  - function xtime;
  - typedef column_t (4×8-bit bytes).
- Sub-module mix_column_comb: combinational forward/inverse combine for one column from its registered products. It is instantiated NCOL times in S2. The inverse port is present only under INV_MIX_EN.

## Test plan
- Forward, NCOL=1, beat 32'hdb135345 -> out_data = 32'h8e4da1bc, out_valid exactly two edges after acceptance.
- Forward, NCOL=4, beat {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5} -> {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}.
- Inverse (INV_MIX_EN), beat 32'h8e4da1bc with in_inv=1 -> 32'hdb135345. In the same run, alternate in_inv beat-to-beat with back-to-back valid, and check that each output uses its own mode.
- Backpressure: stream 8 beats (2d26314c → expected 4d7ebdf8, among others) while holding out_ready low for 5 cycles mid-stream -> in_ready = 0 during the stall, out_data held stable, no beat lost or duplicated, and order preserved.
- Reset mid-stream: pulse rst_n low with both stages full -> out_valid = 0 and in_ready = 1 immediately, and no stale beat emerges after release.
- Forward-only build: send in_inv = 1 with 32'hdb135345 -> output 32'h8e4da1bc and err_inv = 1, sticky until reset.
